// File: rtl/operand_pair_fifo_if.sv
// Handshake bundle for operand_pair_fifo: input pair channel, head-pair channel and status.
`default_nettype none

interface operand_pair_fifo_if #(
  parameter int WIDTH   = 8,
  parameter int DEPTH   = 4,
  parameter int STALL_W = 16
);
  logic [WIDTH-1:0]             a_i;
  logic [WIDTH-1:0]             b_i;
  logic                         in_valid_i;
  logic                         in_ready_o;
  logic [WIDTH-1:0]             a_o;
  logic [WIDTH-1:0]             b_o;
  logic [WIDTH:0]               sum_o;
  logic                         out_valid_o;
  logic                         out_ready_i;
  logic [$clog2(DEPTH+1)-1:0]   count_o;
  logic [STALL_W-1:0]           stall_cnt_o;

  modport master (
    output a_i, b_i, in_valid_i, out_ready_i,
    input  in_ready_o, a_o, b_o, sum_o, out_valid_o, count_o, stall_cnt_o
  );

  modport slave (
    input  a_i, b_i, in_valid_i, out_ready_i,
    output in_ready_o, a_o, b_o, sum_o, out_valid_o, count_o, stall_cnt_o
  );
endinterface

`default_nettype wire

// File: rtl/operand_pair_fifo.sv
// Show-ahead FIFO of operand pairs presenting the head pair and its unsigned sum,
// with occupancy count, synchronous flush and a saturating stall counter.
`default_nettype none

module operand_pair_fifo #(
  parameter int WIDTH   = 8,
  parameter int DEPTH   = 4,
  parameter int STALL_W = 16
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                clear_i,
  operand_pair_fifo_if.slave  bus
);
  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = $clog2(DEPTH + 1);
  localparam logic [CNT_W-1:0] FULL_COUNT = CNT_W'(DEPTH);

  logic [WIDTH-1:0]   mem_a [DEPTH];
  logic [WIDTH-1:0]   mem_b [DEPTH];
  logic [PTR_W-1:0]   wr_ptr;
  logic [PTR_W-1:0]   rd_ptr;
  logic [CNT_W-1:0]   count;
  logic [STALL_W-1:0] stall_cnt;

  logic in_ready;
  logic out_valid;
  logic push;
  logic pop;
  logic stalled;

  // Status is a function of the registered count only, never of the handshake inputs.
  assign in_ready  = (count != FULL_COUNT);
  assign out_valid = (count != '0);
  assign push      = bus.in_valid_i && in_ready;
  assign pop       = out_valid && bus.out_ready_i;
  assign stalled   = bus.in_valid_i && !in_ready;

  always_ff @(posedge clk) begin
    if (push && !clear_i) begin
      mem_a[wr_ptr] <= bus.a_i;
      mem_b[wr_ptr] <= bus.b_i;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      count     <= '0;
      stall_cnt <= '0;
    end else if (clear_i) begin
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      count     <= '0;
      stall_cnt <= '0;
    end else begin
      if (push) begin
        wr_ptr <= wr_ptr + PTR_W'(1);
      end
      if (pop) begin
        rd_ptr <= rd_ptr + PTR_W'(1);
      end
      case ({push, pop})
        2'b10:   count <= count + CNT_W'(1);
        2'b01:   count <= count - CNT_W'(1);
        default: count <= count;
      endcase
      if (stalled && (stall_cnt != '1)) begin
        stall_cnt <= stall_cnt + STALL_W'(1);
      end
    end
  end

  assign bus.in_ready_o  = in_ready;
  assign bus.out_valid_o = out_valid;
  assign bus.a_o         = mem_a[rd_ptr];
  assign bus.b_o         = mem_b[rd_ptr];
  assign bus.sum_o       = {1'b0, mem_a[rd_ptr]} + {1'b0, mem_b[rd_ptr]};
  assign bus.count_o     = count;
  assign bus.stall_cnt_o = stall_cnt;

endmodule

`default_nettype wire

// File: tb/tb_operand_pair_fifo.sv
// Scoreboard bench for operand_pair_fifo: default instance plus a 3-bit stall-counter instance sharing stimulus.
`default_nettype none

module tb_operand_pair_fifo;
  localparam int WIDTH = 8;
  localparam int DEPTH = 4;

  logic clk;
  logic rst_n;
  logic clear_i;

  int total = 0;
  int bad   = 0;

  logic [2*WIDTH-1:0] sb_q[$];
  int exp_stall_big = 0;
  int exp_stall_small = 0;

  operand_pair_fifo_if #(.WIDTH(WIDTH), .DEPTH(DEPTH), .STALL_W(16)) m_if ();
  operand_pair_fifo_if #(.WIDTH(WIDTH), .DEPTH(DEPTH), .STALL_W(3))  s_if ();

  assign s_if.a_i         = m_if.a_i;
  assign s_if.b_i         = m_if.b_i;
  assign s_if.in_valid_i  = m_if.in_valid_i;
  assign s_if.out_ready_i = m_if.out_ready_i;

  operand_pair_fifo #(.WIDTH(WIDTH), .DEPTH(DEPTH), .STALL_W(16)) u_dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .clear_i (clear_i),
    .bus     (m_if.slave)
  );

  operand_pair_fifo #(.WIDTH(WIDTH), .DEPTH(DEPTH), .STALL_W(3)) u_dut_small (
    .clk     (clk),
    .rst_n   (rst_n),
    .clear_i (clear_i),
    .bus     (s_if.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%0d expected=%0d", tag, got, exp);
    end
  endtask

  // Apply one cycle of stimulus; returns just after the rising edge that consumes it.
  task automatic drive(input logic v, input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b,
                       input logic rdy, input logic clr);
    m_if.in_valid_i  = v;
    m_if.a_i         = a;
    m_if.b_i         = b;
    m_if.out_ready_i = rdy;
    clear_i          = clr;
    @(posedge clk);
    #1;
  endtask

  // Monitor: status checked against the queue model, popped pairs against the scoreboard.
  always @(negedge clk) begin
    logic model_push;
    logic model_pop;
    logic [2*WIDTH-1:0] pair;
    if (!rst_n) begin
      sb_q.delete();
      exp_stall_big   = 0;
      exp_stall_small = 0;
    end else begin
      check("count",     32'(m_if.count_o),     32'(sb_q.size()));
      check("out_valid", 32'(m_if.out_valid_o), 32'(sb_q.size() != 0));
      check("in_ready",  32'(m_if.in_ready_o),  32'(sb_q.size() != DEPTH));
      check("stall",     32'(m_if.stall_cnt_o), 32'(exp_stall_big));
      check("stall_s",   32'(s_if.stall_cnt_o), 32'(exp_stall_small));
      model_push = m_if.in_valid_i && (sb_q.size() != DEPTH);
      model_pop  = m_if.out_ready_i && (sb_q.size() != 0);
      if (clear_i) begin
        sb_q.delete();
        exp_stall_big   = 0;
        exp_stall_small = 0;
      end else begin
        if (m_if.in_valid_i && (sb_q.size() == DEPTH)) begin
          if (exp_stall_big < 65535) exp_stall_big++;
          if (exp_stall_small < 7)   exp_stall_small++;
        end
        if (model_pop) begin
          pair = sb_q.pop_front();
          check("pop_a",   32'(m_if.a_o),   32'(pair[2*WIDTH-1:WIDTH]));
          check("pop_b",   32'(m_if.b_o),   32'(pair[WIDTH-1:0]));
          check("pop_sum", 32'(m_if.sum_o), 32'(pair[2*WIDTH-1:WIDTH]) + 32'(pair[WIDTH-1:0]));
        end
        if (model_push) sb_q.push_back({m_if.a_i, m_if.b_i});
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: got=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    rst_n            = 1'b0;
    clear_i          = 1'b0;
    m_if.in_valid_i  = 1'b0;
    m_if.out_ready_i = 1'b0;
    m_if.a_i         = '0;
    m_if.b_i         = '0;
    repeat (2) @(posedge clk);
    #1;
    check("rst_count", 32'(m_if.count_o), 0);
    check("rst_ready", 32'(m_if.in_ready_o), 1);
    check("rst_valid", 32'(m_if.out_valid_o), 0);
    rst_n = 1'b1;

    // Fill, then stall against a full FIFO.
    drive(1, 1, 2, 0, 0);
    drive(1, 3, 4, 0, 0);
    drive(1, 5, 6, 0, 0);
    drive(1, 7, 8, 0, 0);
    repeat (3) drive(1, 9, 9, 0, 0);
    check("full_count", 32'(m_if.count_o), 4);
    check("full_ready", 32'(m_if.in_ready_o), 0);
    check("full_stall", 32'(m_if.stall_cnt_o), 3);
    check("head_a",     32'(m_if.a_o), 1);
    check("head_b",     32'(m_if.b_o), 2);
    check("head_sum",   32'(m_if.sum_o), 3);

    // Saturation of the 3-bit counter while the wide one keeps climbing.
    repeat (10) drive(1, 9, 9, 0, 0);
    check("sat_small", 32'(s_if.stall_cnt_o), 7);
    check("sat_big",   32'(m_if.stall_cnt_o), 13);

    // Drain in order.
    repeat (4) drive(0, 0, 0, 1, 0);
    check("drain_valid", 32'(m_if.out_valid_o), 0);
    check("drain_count", 32'(m_if.count_o), 0);

    // Widest operands need the extra sum bit.
    drive(1, 255, 255, 0, 0);
    check("wide_valid", 32'(m_if.out_valid_o), 1);
    check("wide_sum",   32'(m_if.sum_o), 510);
    drive(0, 0, 0, 1, 0);

    // Concurrent push/pop at count 2 across pointer wrap.
    drive(1, 10, 11, 0, 0);
    drive(1, 12, 13, 0, 0);
    for (int i = 0; i < 10; i++) begin
      drive(1, 8'(20 + i), 8'(30 + i), 1, 0);
      check("pp_count", 32'(m_if.count_o), 2);
    end

    // Full with consumer ready: pop only.
    drive(1, 40, 41, 0, 0);
    drive(1, 42, 43, 0, 0);
    check("refull_count", 32'(m_if.count_o), 4);
    drive(1, 50, 51, 1, 0);
    check("full_pop_count", 32'(m_if.count_o), 3);
    check("full_pop_ready", 32'(m_if.in_ready_o), 1);

    // Clear wins over push and pop.
    drive(1, 99, 99, 1, 1);
    check("clr_count", 32'(m_if.count_o), 0);
    check("clr_valid", 32'(m_if.out_valid_o), 0);
    check("clr_stall", 32'(m_if.stall_cnt_o), 0);
    drive(0, 0, 0, 1, 0);
    check("clr_dropped", 32'(m_if.out_valid_o), 0);

    // Asynchronous reset mid-stream with 3 pairs stored.
    drive(1, 60, 61, 0, 0);
    drive(1, 62, 63, 0, 0);
    drive(1, 64, 65, 0, 0);
    m_if.in_valid_i = 1'b0;
    #2;
    rst_n = 1'b0;
    #1;
    check("arst_count", 32'(m_if.count_o), 0);
    check("arst_valid", 32'(m_if.out_valid_o), 0);
    check("arst_ready", 32'(m_if.in_ready_o), 1);
    check("arst_stall", 32'(m_if.stall_cnt_o), 0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    drive(1, 5, 6, 0, 0);
    check("post_rst_count", 32'(m_if.count_o), 1);
    check("post_rst_a",     32'(m_if.a_o), 5);
    check("post_rst_b",     32'(m_if.b_o), 6);
    drive(0, 0, 0, 1, 0);
    check("post_rst_empty", 32'(m_if.out_valid_o), 0);
    drive(0, 0, 0, 0, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/operand_pair_fifo.md
# operand_pair_fifo

Parametrised buffered capture stage for paired operands `a`/`b`, generalising the team's single-register operand capture. Accepts one operand pair per cycle over a valid/ready handshake, stores up to `DEPTH` pairs in order, and presents the head pair plus its unsigned sum to the downstream consumer. It also provides:
- occupancy count,
- synchronous flush,
- a saturating stall counter for back-pressure monitoring.

## Interface
Parameters:
- `WIDTH`, 8, operand width in bits (≥1).
- `DEPTH`, 4, pair storage depth; power of two, ≥2.
- `STALL_W`, 16, stall counter width (≥1).

Ports:
- `clk`  in  1  clock; all state updates on rising edge.
- `rst_n`  in  1  asynchronous reset, active-low.
- `clear_i`  in  1  synchronous flush; empties storage, zeroes stall counter.
- `a_i`  in  WIDTH  operand a of incoming pair.
- `b_i`  in  WIDTH  operand b of incoming pair.
- `in_valid_i`  in  1  incoming pair valid.
- `in_ready_o`  out  1  block can accept a pair this cycle.
- `a_o`  out  WIDTH  operand a of head pair.
- `b_o`  out  WIDTH  operand b of head pair.
- `sum_o`  out  WIDTH+1  `a_o + b_o`, zero-extended, no truncation.
- `out_valid_o`  out  1  head pair valid.
- `out_ready_i`  in  1  consumer takes head pair this cycle.
- `count_o`  out  $clog2(DEPTH+1)  pairs currently stored.
- `stall_cnt_o`  out  STALL_W  cycles with `in_valid_i`=1 and `in_ready_o`=0; saturating.

## Operation
- **Push:** occurs when `in_valid_i && in_ready_o`. `a_i`/`b_i` are written at the write pointer, which then advances.
- **Pop:** occurs when `out_valid_o && out_ready_i`. The read pointer advances.
- **Pointers:** `$clog2(DEPTH)` bits, wrap from `DEPTH-1` to 0. Full/empty are derived from `count`, not from pointer equality.
- **Status outputs:**
  - `in_ready_o = (count != DEPTH)`.
  - `out_valid_o = (count != 0)`.
  - Both are combinational from registered `count` only; neither depends on `in_valid_i` or `out_ready_i`.
- **Count update:** push only → +1; pop only → −1; push and pop together → unchanged, both pointers advance. Push when full is impossible because `in_ready_o`=0. The same holds when full with `out_ready_i`=1: no push that cycle.
- **Ordering:** strict FIFO. Show-ahead: `a_o`/`b_o` always reflect storage at the read pointer.
- **`sum_o`:** combinational WIDTH+1 add of `a_o` and `b_o`. Its value when `out_valid_o`=0 is don't-care.
- **Stall counter:** increments by 1 each cycle with `in_valid_i && !in_ready_o`. It holds at all-ones, with no wrap.
- **`clear_i`:**
  - Sets count and both pointers to 0 and the stall counter to 0.
  - Has priority over push and pop in the same cycle: a pair offered in that cycle is dropped, and any pop is discarded.
  - `in_ready_o` still shows the pre-clear value during the clear cycle.
- **Reset (`rst_n`=0):** asynchronous. Count, pointers and stall counter go to 0 immediately. Resulting outputs: `in_ready_o`=1, `out_valid_o`=0, `count_o`=0, `stall_cnt_o`=0.
  - Storage contents are not reset.
  - `a_o`/`b_o`/`sum_o` are don't-care until the first push.
- **Reset mid-operation:** all stored pairs are lost. No pop is reported for them.

## Timing
- Push in cycle N → pair visible on `a_o`/`b_o`, with `out_valid_o`=1, from cycle N+1 when the FIFO was empty. Minimum latency is 1 cycle; there is no fall-through.
- Pop in cycle N → next pair, or `out_valid_o`=0, from cycle N+1.
- Full throughput: with `in_valid_i`=1 and `out_ready_i`=1 continuously, one pair per cycle after the first.
- `count_o` and `stall_cnt_o` are registered; they update the cycle after the event.
- Deasserting `rst_n` takes effect on the first rising edge after release. Release is synchronised externally.

## Test plan
- **Reset values:** assert `rst_n`=0 mid-stream with 3 pairs stored → same cycle `count_o`=0, `out_valid_o`=0, `in_ready_o`=1, `stall_cnt_o`=0. After release, the next push of (5,6) appears alone at the head.
- **Fill, then stall:**
  - Stimulus: WIDTH=8, DEPTH=4, `out_ready_i`=0. Push (1,2),(3,4),(5,6),(7,8), then hold `in_valid_i`=1 with (9,9) for 3 more cycles.
  - Response: `count_o`=4, `in_ready_o`=0, `stall_cnt_o`=3. Head (1,2) with `sum_o`=3. Pair (9,9) is not stored.
- **Drain order and width:**
  - Stimulus: from full, `out_ready_i`=1 for 4 cycles.
  - Response: `a_o`/`b_o` sequence (1,2),(3,4),(5,6),(7,8), then `out_valid_o`=0.
  - Also push (255,255) → `sum_o`=510, 9 bits, no overflow.
- **Simultaneous push/pop and wrap:**
  - Stimulus: `count_o`=2, then push and pop every cycle for 10 cycles with incrementing data.
  - Response: `count_o` stays 2 and the output order is preserved across pointer wrap.
  - Also, when full with `out_ready_i`=1: pop occurs, no push, `count_o`→3.
- **Clear priority:**
  - Stimulus: 3 pairs stored; in one cycle assert `clear_i`, `in_valid_i`=1 and `out_ready_i`=1.
  - Response: next cycle `count_o`=0, `out_valid_o`=0, `stall_cnt_o`=0. The offered pair is never output.
- **Stall saturation:**
  - Stimulus: STALL_W=3, FIFO full, `in_valid_i`=1 for 10 cycles.
  - Response: `stall_cnt_o` climbs to 7 and holds at 7.
